multi_port_fifo: RTL and testbench

- Parametrised N_WR-write / N_RD-read synchronous circular FIFO.
- Serves as the multi-issue instruction queue and ROB-style buffer in the superscalar Tomasulo core.
- Each cycle it pushes up to N_WR consecutive entries and pops up to N_RD.
- Exposes the head N_RD entries combinationally, plus level, almost-full and pointer rollback for branch/exception recovery.

---
 rtl/multi_port_fifo.sv | 107 ++++++++++
 tb/tb_multi_port_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_fifo.sv
// Multi-lane circular FIFO: up to N_WR pushes and N_RD pops per cycle, with the head
// N_RD entries exposed combinationally and both pointers reloadable for recovery.
module multi_port_fifo #(
    parameter int DEPTH     = 32,
    parameter int WIDTH     = 32,
    parameter int PTR_WIDTH = 6,
    parameter int N_WR      = 2,
    parameter int N_RD      = 2,
    parameter int CNT_W     = 2,
    parameter int AFULL_THR = 28
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CNT_W-1:0]        w_cnt,
    input  logic [N_WR*WIDTH-1:0]   din,
    input  logic [CNT_W-1:0]        r_cnt,
    output logic [N_RD*WIDTH-1:0]   dout,
    output logic [N_RD-1:0]         dout_vld,
    output logic [PTR_WIDTH-1:0]    level,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    w_fail,
    output logic                    r_fail,
    output logic [PTR_WIDTH-1:0]    w_ptr,
    output logic [PTR_WIDTH-1:0]    r_ptr,
    input  logic                    change_w_ptr_en,
    input  logic [PTR_WIDTH-1:0]    change_w_ptr_value,
    input  logic                    change_r_ptr_en,
    input  logic [PTR_WIDTH-1:0]    change_r_ptr_value
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [PTR_WIDTH-1:0] DEPTH_C = PTR_WIDTH'(DEPTH);
    localparam logic [PTR_WIDTH-1:0] AFULL_C = PTR_WIDTH'(AFULL_THR);
    localparam logic [CNT_W-1:0]     N_WR_C  = CNT_W'(N_WR);
    localparam logic [CNT_W-1:0]     N_RD_C  = CNT_W'(N_RD);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] free;
    logic                 w_acc;
    logic                 r_acc;
    logic [AW-1:0]        w_addr [N_WR];
    logic [AW-1:0]        r_addr [N_RD];

    // Status is derived from the registered pointers only, never from this cycle's requests.
    assign level       = w_ptr - r_ptr;
    assign free        = DEPTH_C - level;
    assign full        = (level == DEPTH_C);
    assign empty       = (level == '0);
    assign almost_full = (level >= AFULL_C);

    assign w_acc = !change_w_ptr_en && (w_cnt != '0) && (w_cnt <= N_WR_C)
                   && (PTR_WIDTH'(w_cnt) <= free);
    assign r_acc = !change_r_ptr_en && (r_cnt != '0) && (r_cnt <= N_RD_C)
                   && (PTR_WIDTH'(r_cnt) <= level);

    assign w_fail = !reset && (w_cnt != '0) && !w_acc;
    assign r_fail = !reset && (r_cnt != '0) && !r_acc;

    // Lane addresses wrap on the low AW bits, so a burst may straddle DEPTH-1 -> 0.
    always_comb begin
        for (int k = 0; k < N_WR; k++) begin
            w_addr[k] = AW'(w_ptr) + AW'(k);
        end
        for (int k = 0; k < N_RD; k++) begin
            r_addr[k] = AW'(r_ptr) + AW'(k);
        end
    end

    always_comb begin
        dout     = '0;
        dout_vld = '0;
        for (int k = 0; k < N_RD; k++) begin
            dout[k*WIDTH +: WIDTH] = mem[r_addr[k]];
            dout_vld[k]            = (level > PTR_WIDTH'(k));
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_WR; k++) begin
            if (!reset && w_acc && (CNT_W'(k) < w_cnt)) begin
                mem[w_addr[k]] <= din[k*WIDTH +: WIDTH];
            end
        end
    end

    // A pointer load takes priority over a push/pop on that same pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (change_w_ptr_en) begin
                w_ptr <= change_w_ptr_value;
            end else if (w_acc) begin
                w_ptr <= w_ptr + PTR_WIDTH'(w_cnt);
            end
            if (change_r_ptr_en) begin
                r_ptr <= change_r_ptr_value;
            end else if (r_acc) begin
                r_ptr <= r_ptr + PTR_WIDTH'(r_cnt);
            end
        end
    end

endmodule

// File: tb/tb_multi_port_fifo.sv
// Scoreboard bench for multi_port_fifo: the driver predicts each cycle's outputs from an
// unbounded-pointer reference model; a separate monitor pops and compares them.
module tb_multi_port_fifo;

    localparam int DEPTH = 8;
    localparam int PW    = 4;
    localparam int WIDTH = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      w_cnt;
    logic [2*WIDTH-1:0] din;
    logic [1:0]      r_cnt;
    logic [2*WIDTH-1:0] dout;
    logic [1:0]      dout_vld;
    logic [PW-1:0]   level;
    logic            full, empty, almost_full, w_fail, r_fail;
    logic [PW-1:0]   w_ptr, r_ptr;
    logic            change_w_ptr_en, change_r_ptr_en;
    logic [PW-1:0]   change_w_ptr_value, change_r_ptr_value;

    always #5 clk = ~clk;

    multi_port_fifo #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .PTR_WIDTH(PW), .N_WR(2), .N_RD(2),
        .CNT_W(2), .AFULL_THR(6)
    ) dut (
        .clk(clk), .reset(reset), .w_cnt(w_cnt), .din(din), .r_cnt(r_cnt),
        .dout(dout), .dout_vld(dout_vld), .level(level), .full(full), .empty(empty),
        .almost_full(almost_full), .w_fail(w_fail), .r_fail(r_fail),
        .w_ptr(w_ptr), .r_ptr(r_ptr),
        .change_w_ptr_en(change_w_ptr_en), .change_w_ptr_value(change_w_ptr_value),
        .change_r_ptr_en(change_r_ptr_en), .change_r_ptr_value(change_r_ptr_value)
    );

    typedef struct {
        logic [PW-1:0] level, wptr, rptr;
        logic          full, empty, af, wf, rf;
        logic [1:0]    vld, known;
        logic [31:0]   d0, d1;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;

    // Reference model: entries live at absolute (never-wrapping) integer positions.
    int          wp = 0;
    int          rp = 0;
    logic [31:0] mem_m [DEPTH];
    bit          known [DEPTH];

    function automatic int md(int x, int m);
        return ((x % m) + m) % m;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic step(int wc, int rc, bit cwe = 0, int dw = 0, bit cre = 0, int dr = 0,
                        bit rs = 0);
        exp_t        e;
        int          lvl, nwp, nrp;
        bit          wacc, racc;
        logic [63:0] d;
        @(negedge clk);
        d    = {$urandom, $urandom};
        lvl  = wp - rp;
        wacc = !cwe && wc != 0 && wc <= 2 && wc <= DEPTH - lvl;
        racc = !cre && rc != 0 && rc <= 2 && rc <= lvl;
        e.level = PW'(lvl);
        e.wptr  = PW'(md(wp, 16));
        e.rptr  = PW'(md(rp, 16));
        e.full  = (lvl == DEPTH);
        e.empty = (lvl == 0);
        e.af    = (lvl >= 6);
        e.wf    = !rs && wc != 0 && !wacc;
        e.rf    = !rs && rc != 0 && !racc;
        e.vld   = {lvl > 1, lvl > 0};
        e.known = {known[md(rp + 1, DEPTH)], known[md(rp, DEPTH)]};
        e.d0    = mem_m[md(rp, DEPTH)];
        e.d1    = mem_m[md(rp + 1, DEPTH)];
        exp_q.push_back(e);

        reset              = rs;
        w_cnt              = 2'(wc);
        r_cnt              = 2'(rc);
        din                = d;
        change_w_ptr_en    = cwe;
        change_w_ptr_value = PW'(md(rp + dw, 16));
        change_r_ptr_en    = cre;
        change_r_ptr_value = PW'(md(wp - dr, 16));

        if (rs) begin
            wp = 0;
            rp = 0;
        end else begin
            if (wacc) begin
                for (int k = 0; k < wc; k++) begin
                    mem_m[md(wp + k, DEPTH)] = d[k*32 +: 32];
                    known[md(wp + k, DEPTH)] = 1'b1;
                end
            end
            nwp = cwe ? rp + dw : (wacc ? wp + wc : wp);
            nrp = cre ? wp - dr : (racc ? rp + rc : rp);
            wp  = nwp;
            rp  = nrp;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("level", 32'(level), 32'(e.level));
                chk("w_ptr", 32'(w_ptr), 32'(e.wptr));
                chk("r_ptr", 32'(r_ptr), 32'(e.rptr));
                chk("full", 32'(full), 32'(e.full));
                chk("empty", 32'(empty), 32'(e.empty));
                chk("almost_full", 32'(almost_full), 32'(e.af));
                chk("dout_vld", 32'(dout_vld), 32'(e.vld));
                chk("w_fail", 32'(w_fail), 32'(e.wf));
                chk("r_fail", 32'(r_fail), 32'(e.rf));
                if (e.vld[0] && e.known[0]) chk("dout_lane0", dout[31:0], e.d0);
                if (e.vld[1] && e.known[1]) chk("dout_lane1", dout[63:32], e.d1);
            end
        end
    end

    initial begin : driver
        int lvl;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        reset = 1'b1; w_cnt = '0; r_cnt = '0; din = '0;
        change_w_ptr_en = 1'b0; change_r_ptr_en = 1'b0;
        change_w_ptr_value = '0; change_r_ptr_value = '0;
        repeat (2) @(posedge clk);

        // First push, then observe head; drain; fill to full and overflow.
        step(2, 0);
        step(0, 0);
        step(0, 2);
        for (int i = 0; i < 4; i++) step(2, 0);
        step(1, 0);
        step(1, 1);
        step(0, 2);
        step(0, 2);
        step(0, 2);
        step(0, 2);
        step(0, 1);
        step(0, 0);
        // Lane-count overflow on both sides.
        step(3, 0);
        step(0, 3);

        // Bring both pointers to 7, then a push straddling index 7 -> 0.
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            step(1, 0);
            step(0, 1);
        end
        step(2, 0);
        step(0, 0);
        // Level 4 with simultaneous push/pop, then level 5 with a write rollback.
        step(2, 0);
        step(2, 2);
        step(0, 0);
        step(1, 0);
        step(1, 0, 1, 2);
        step(0, 0);
        // Read rollback re-exposing all DEPTH entries, then both pointers in one cycle.
        step(0, 0, 0, 0, 1, DEPTH);
        step(0, 0);
        lvl = wp - rp;
        step(0, 0, 1, lvl + 1, 1, 1);
        step(0, 0);
        // Reset in the middle of traffic.
        step(2, 1, 0, 0, 0, 0, 1);
        step(0, 0);

        for (int i = 0; i < 2000; i++) begin
            int r;
            lvl = wp - rp;
            r   = $urandom_range(0, 99);
            if (r < 5)
                step($urandom_range(0, 3), 0, 1, $urandom_range(0, lvl));
            else if (r < 10)
                step(0, $urandom_range(0, 3), 0, 0, 1, $urandom_range(lvl, DEPTH));
            else if (r < 11)
                step($urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0, 0, 1);
            else
                step($urandom_range(0, 3), $urandom_range(0, 3));
        end

        @(negedge clk);
        reset = 1'b0; w_cnt = '0; r_cnt = '0;
        change_w_ptr_en = 1'b0; change_r_ptr_en = 1'b0;
        #4;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
